// File: rtl/mult_pipe_sched_if.sv
// Requester-side bundle of the shared-multiplier scheduler: request/operand lanes,
// one-hot grant and the tagged response strobe.
interface mult_pipe_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] a_in;
  logic [8*NREQ-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;

  modport master (
    output req, a_in, b_in,
    input  gnt, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mult_pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency pipelined 8x8 multiplier among NREQ
// requesters; a tag pipe matched to the multiplier latency routes each product back.
module mult_pipe_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int LATENCY = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_i,
  mult_pipe_sched_if.slave            bus,
  output logic [7:0]                  mul_n1_o,
  output logic [7:0]                  mul_n2_o,
  input  logic [15:0]                 mul_result_i,
  output logic [$clog2(LATENCY+2):0]  in_flight_o,
  output logic                        idle_o
);

  localparam int IFW = $clog2(LATENCY+2) + 1;
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  cand_id [NREQ];
  logic [NREQ-1:0] cand_req;
  logic            win_valid;
  logic [IDW-1:0]  win_id;

  logic [7:0]      n1_q, n1_d;
  logic [7:0]      n2_q, n2_d;

  logic [LATENCY:0] tag_v_q, tag_v_d;
  logic [IDW-1:0]   tag_id_q [LATENCY+1];

  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [15:0]     rsp_data_q, rsp_data_d;
  logic [IFW-1:0]  in_flight_q, in_flight_d;

  // Candidate k is the requester k+1 places after the last winner.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_rot
      assign cand_id[gi]  = IDW'((int'(last_q) + gi + 1) % NREQ);
      assign cand_req[gi] = bus.req[cand_id[gi]];
    end
  endgenerate

  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_valid = 1'b1;
        win_id    = cand_id[k];
      end
    end
    if (!en_i || rst) begin
      win_valid = 1'b0;
      win_id    = '0;
    end
  end

  always_comb begin
    bus.gnt = '0;
    if (win_valid) begin
      bus.gnt[win_id] = 1'b1;
    end
  end

  always_comb begin
    last_d = last_q;
    n1_d   = n1_q;
    n2_d   = n2_q;
    if (win_valid) begin
      last_d = win_id;
      n1_d   = bus.a_in[{win_id, 3'b000} +: 8];
      n2_d   = bus.b_in[{win_id, 3'b000} +: 8];
    end
  end

  // The multiplier never stalls, so the tag pipe shifts every cycle.
  assign tag_v_d = {tag_v_q[LATENCY-1:0], win_valid};

  always_comb begin
    rsp_valid_d = tag_v_q[LATENCY];
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (tag_v_q[LATENCY]) begin
      rsp_id_d   = tag_id_q[LATENCY];
      rsp_data_d = mul_result_i;
    end
  end

  always_comb begin
    in_flight_d = in_flight_q;
    unique case ({win_valid, rsp_valid_q})
      2'b10:   in_flight_d = in_flight_q + IFW'(1);
      2'b01:   in_flight_d = in_flight_q - IFW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= LAST_RST;
      n1_q        <= '0;
      n2_q        <= '0;
      tag_v_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      in_flight_q <= '0;
    end else begin
      last_q      <= last_d;
      n1_q        <= n1_d;
      n2_q        <= n2_d;
      tag_v_q     <= tag_v_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      in_flight_q <= in_flight_d;
    end
  end

  generate
    for (gi = 0; gi <= LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_id_q[0] <= '0;
          end else begin
            tag_id_q[0] <= win_id;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_id_q[gi] <= '0;
          end else begin
            tag_id_q[gi] <= tag_id_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign mul_n1_o      = n1_q;
  assign mul_n2_o      = n2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign in_flight_o   = in_flight_q;
  assign idle_o        = (in_flight_q == '0) && !win_valid;

endmodule

// File: tb/tb_mult_pipe_sched.sv
// Scoreboard bench for mult_pipe_sched: a reference arbiter queues expected responses
// on every grant and a negedge monitor matches each response strobe against them.
module tb_mult_pipe_sched;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int LATENCY = 8;
  localparam int IFW     = $clog2(LATENCY+2) + 1;
  localparam int RSP_LAT = LATENCY + 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en  = 1'b0;
  logic [7:0]     mul_n1, mul_n2;
  logic [15:0]    mul_result;
  logic [IFW-1:0] in_flight;
  logic           idle;

  mult_pipe_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mult_pipe_sched #(.NREQ(NREQ), .IDW(IDW), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .bus          (bus),
    .mul_n1_o     (mul_n1),
    .mul_n2_o     (mul_n2),
    .mul_result_i (mul_result),
    .in_flight_o  (in_flight),
    .idle_o       (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier environment: result in cycle c is the product of the operands of cycle c-LATENCY.
  logic [15:0] mpipe [LATENCY];
  always @(posedge clk) begin
    mpipe[0] <= 16'($signed({8'h00, mul_n1}) * $signed({{8{mul_n2[7]}}, mul_n2}));
    for (int k = 1; k < LATENCY; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[LATENCY-1];

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
    int          issue;
  } exp_t;

  exp_t            sb[$];
  int              errors = 0;
  int              checks = 0;
  int              last_m = NREQ - 1;
  logic [NREQ-1:0] exp_gnt = '0;
  int              max_if = 0;

  function automatic logic [15:0] refprod(logic [7:0] a, logic [7:0] b);
    int bs;
    bs = b[7] ? int'(b) - 256 : int'(b);
    return 16'(int'(a) * bs);
  endfunction

  function automatic logic [8*NREQ-1:0] rnd_bus();
    logic [8*NREQ-1:0] v;
    for (int k = 0; k < NREQ; k++) v[k*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(logic e, logic [NREQ-1:0] r, logic [8*NREQ-1:0] a, logic [8*NREQ-1:0] b);
    int w;
    exp_t ent;
    @(posedge clk);
    #1;
    en       = e;
    bus.req  = r;
    bus.a_in = a;
    bus.b_in = b;
    exp_gnt  = '0;
    w        = -1;
    if (e && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && r[(last_m + k) % NREQ]) w = (last_m + k) % NREQ;
      end
    end
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      last_m     = w;
      ent.id     = w;
      ent.data   = refprod(a[w*8 +: 8], b[w*8 +: 8]);
      ent.due    = cyc + RSP_LAT;
      ent.issue  = cyc;
      sb.push_back(ent);
      $display("cycle %0d: grant id=%0d a=0x%02h b=0x%02h", cyc, w, a[w*8 +: 8], b[w*8 +: 8]);
    end
    @(negedge clk);
    chk("gnt", int'(bus.gnt), int'(exp_gnt));
  endtask

  task automatic idle_cycles(int n);
    repeat (n) step(1'b1, '0, rnd_bus(), rnd_bus());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    en      = 1'b0;
    bus.req = '0;
    sb.delete();
    last_m  = NREQ - 1;
    exp_gnt = '0;
    #1;
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_rsp_data", int'(bus.rsp_data), 0);
    chk("rst_mul_n1", int'(mul_n1), 0);
    chk("rst_mul_n2", int'(mul_n2), 0);
    chk("rst_in_flight", int'(in_flight), 0);
    chk("rst_gnt", int'(bus.gnt), 0);
    $display("cycle %0d: reset pulse", cyc);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every response strobe must match the oldest outstanding issue, on time.
  initial begin
    int   cnt;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0;
        foreach (sb[k]) if (sb[k].issue < cyc) cnt++;
        chk("in_flight", int'(in_flight), cnt);
        chk("idle", int'(idle), int'(cnt == 0 && exp_gnt == '0));
        if (int'(in_flight) > max_if) max_if = int'(in_flight);
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            chk("rsp_unexpected", int'(bus.rsp_valid), 0);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", int'(bus.rsp_id), e.id);
            chk("rsp_data", int'(bus.rsp_data), int'(e.data));
            chk("rsp_cycle", cyc, e.due);
            $display("cycle %0d: response id=%0d data=0x%04h", cyc, bus.rsp_id, bus.rsp_data);
          end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("rsp_missing", int'(bus.rsp_valid), 1);
        end
      end
    end
  end

  initial begin
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    do_reset();

    // single op: requester 1, 3 * 5
    step(1'b1, 4'b0010, 32'h0000_0300, 32'h0000_0500);
    idle_cycles(12);

    // signed products on requester 2
    step(1'b1, 4'b0100, 32'h000A_0000, 32'h00FD_0000);
    step(1'b1, 4'b0100, 32'h00FF_0000, 32'h0080_0000);
    step(1'b1, 4'b0100, 32'h0000_0000, 32'h0085_0000);
    idle_cycles(12);

    // round robin from reset
    do_reset();
    repeat (8) step(1'b1, 4'hF, rnd_bus(), rnd_bus());
    idle_cycles(12);

    // en gating
    step(1'b1, 4'b0001, rnd_bus(), rnd_bus());
    repeat (3) step(1'b0, 4'b0001, rnd_bus(), rnd_bus());
    repeat (3) step(1'b1, 4'b0001, rnd_bus(), rnd_bus());
    idle_cycles(12);

    // reset with five operations in flight
    repeat (5) step(1'b1, 4'hF, rnd_bus(), rnd_bus());
    idle_cycles(3);
    do_reset();
    idle_cycles(12);
    step(1'b1, 4'hF, rnd_bus(), rnd_bus());
    idle_cycles(12);

    // saturation
    max_if = 0;
    repeat (40) step(1'b1, 4'hF, rnd_bus(), rnd_bus());
    chk("in_flight_peak", max_if, RSP_LAT);
    idle_cycles(12);

    // random traffic
    repeat (300) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step($urandom_range(0, 7) != 0, NREQ'($urandom), rnd_bus(), rnd_bus());
    end
    idle_cycles(14);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_pipe_sched.md
# mult_pipe_sched

Round-robin scheduler that shares one 8-stage pipelined 8x8 multiplier (n1 unsigned, n2 two's-complement, 16-bit signed result) among NREQ requesters. It grants at most one request per cycle and drives the multiplier operands from a registered issue stage. A tag pipeline matched to the multiplier latency tracks the owner of each in-flight product. Each result is returned with the requester ID as a one-cycle response pulse. It sits between the requesting datapath blocks and the multiplier instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(NREQ)
- LATENCY, 8, clock edges from the multiplier sampling n1/n2 to its result register updating
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  issue enable; 0 blocks new grants, in-flight operations still drain
- req  in  NREQ  per-requester request level, held until granted
- a_in  in  8*NREQ  n1 operand (unsigned); slice i belongs to requester i
- b_in  in  8*NREQ  n2 operand (two's-complement); slice i belongs to requester i
- gnt  out  NREQ  one-hot grant, combinational, asserted in the cycle the request is accepted
- mul_n1  out  8  registered operand to the multiplier n1
- mul_n2  out  8  registered operand to the multiplier n2
- mul_result  in  16  multiplier result
- rsp_valid  out  1  registered one-cycle response strobe
- rsp_id  out  IDW  owner of rsp_data
- rsp_data  out  16  product, equal to mul_result, unmodified
- in_flight  out  clog2(LATENCY+2)+1  number of issued operations not yet responded
- idle  out  1  high when in_flight==0 and no grant in the current cycle

## Operation
- Arbitration:
  - A grant goes to the first asserted req[i] searching from (last+1) mod NREQ; last = ID of the most recent grant.
  - gnt is all-zero when en=0 or req is all-zero.
- Issue, at the edge ending the grant cycle:
  - mul_n1/mul_n2 load a_in/b_in slice of the winner.
  - Tag stage 0 loads {valid=1, id}.
  - With no grant, tag stage 0 loads valid=0 and mul_n1/mul_n2 hold their value.
- Tag pipeline:
  - LATENCY+1 stages of {valid, id}, shifting every edge unconditionally.
  - The multiplier cannot stall, so the pipe has no stall.
- Response:
  - When the final tag stage is valid, at the next edge: rsp_valid<=1, rsp_id<=tag id, rsp_data<=mul_result.
  - Otherwise rsp_valid<=0 and rsp_id/rsp_data hold.
- No backpressure on responses; requesters must accept every rsp_valid pulse addressed to them.
- in_flight:
  - Increments on a grant, decrements on rsp_valid.
  - Both in the same cycle leave it unchanged.
  - Never exceeds LATENCY+2.
- Arithmetic:
  - The block never inspects operand or product values.
  - Zero operands and sign handling are the multiplier's job.
- Reset values (asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_data=0, mul_n1=0, mul_n2=0.
  - All tag valids=0, in_flight=0, last=NREQ-1 (requester 0 has first priority).
  - gnt=0 while rst is high.
- Reset mid-operation:
  - The multiplier pipeline is not reset; its contents are discarded because all tag valids clear.
  - No rsp_valid occurs for operations issued before reset.
- en deasserted mid-stream: operations already granted still respond at their normal cycle.

## Timing
- Grant in cycle T:
  - Operands on mul_n1/mul_n2 in T+1.
  - Product on mul_result in T+1+LATENCY.
  - rsp_valid high in T+2+LATENCY, which is T+10 by default.
- Throughput is one issue per cycle, so back-to-back grants give back-to-back responses in issue order.
- Responses are strictly in issue order, independent of requester.
- A requester may re-request in the cycle after its grant; it gets a grant only when it wins arbitration again.
- req and a_in/b_in are sampled only in the grant cycle.

## Test plan
- Single op: req[1]=1, a=3, b=5 at cycle T. Required: gnt=0010 in T; rsp_valid in T+10 with rsp_id=1, rsp_data=0x000F; in_flight 1 from T+1 to T+10, back to 0 in T+11.
- Signed op: req[2], a=10, b=0xFD (-3). Required: rsp_data=0xFFE2 at T+10. Also a=255, b=0x80 gives 0x8080, and a=0, b=0x85 gives 0x0000.
- Round robin: req=1111 held 8 cycles after reset. Required: grant order 0,1,2,3,0,1,2,3; responses in cycles T+10..T+17 with the same ID order and correct products from a behavioural LATENCY=8 multiplier model.
- en gating: req=0001 held and en dropped for 3 cycles after one grant. Required: no gnt during those 3 cycles; the already-granted response still arrives at T+10; granting resumes the cycle en returns.
- Reset mid-flight: 5 ops issued, then rst pulsed 1 cycle at issue+4. Required: outputs at reset values immediately; no rsp_valid for the 5 ops; next grant goes to requester 0 first.
- Saturation: all requesters request continuously for 40 cycles. Required: in_flight peaks at 10 and stays there; exactly one response per cycle in steady state; gnt always one-hot.
